gun_position: RTL and testbench



---
 rtl/gun_pkg.sv | 27 ++
 rtl/gun_axis.sv | 104 ++++++++++
 rtl/gun_position.sv | 148 ++++++++++++++
 tb/tb_gun_position.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/gun_pkg.sv
// Shared constants and FSM state type for the joystick-to-lightgun converter.
package gun_pkg;

    localparam int unsigned POS_W        = 6;
    localparam int unsigned FRAC_W       = 4;
    localparam int unsigned POS_MAX      = 63;
    localparam int unsigned ACCEL_FRAMES = 8;
    localparam int unsigned ANA_SHIFT    = 3;

    localparam int unsigned ACC_W     = POS_W + FRAC_W;
    localparam int unsigned LEVEL_MAX = 3;
    localparam int unsigned LEVEL_W   = 2;
    localparam int unsigned HOLD_W    = $clog2(ACCEL_FRAMES);
    localparam int unsigned DELTA_W   = FRAC_W + LEVEL_MAX + 2;
    // Two headroom bits: a full accumulator plus the largest step must not wrap.
    localparam int unsigned SUM_W     = ACC_W + 2;

    localparam logic [ACC_W-1:0] ACC_RESET = ACC_W'((POS_MAX / 2) << FRAC_W);
    localparam logic [ACC_W-1:0] ACC_TOP   = ACC_W'((POS_MAX << FRAC_W) | ((1 << FRAC_W) - 1));

    typedef enum logic [1:0] {
        WAIT,
        CALC,
        APPLY
    } gun_state_t;

endpackage

// File: rtl/gun_axis.sv
// One gun axis: hold/acceleration tracking, per-frame delta select and a
// saturating fixed-point position accumulator.
module gun_axis
    import gun_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             calc,
    input  logic             apply,
    input  logic             ana_sel,
    input  logic             dir_neg,
    input  logic             dir_pos,
    input  logic [7:0]       ana,
    output logic [POS_W-1:0] pos,
    output logic             changed_c
);

    localparam logic signed [SUM_W-1:0] SUM_TOP = {{(SUM_W-ACC_W){1'b0}}, ACC_TOP};

    logic [ACC_W-1:0]          acc;
    logic [HOLD_W-1:0]         hold;
    logic [LEVEL_W-1:0]        level;
    logic                      last_neg;
    logic signed [DELTA_W-1:0] delta;

    logic                      single;
    logic [HOLD_W-1:0]         hold_base;
    logic [HOLD_W-1:0]         hold_nxt;
    logic [LEVEL_W-1:0]        level_base;
    logic [LEVEL_W-1:0]        level_nxt;
    logic [DELTA_W-1:0]        mag;
    logic signed [DELTA_W-1:0] ana_ext;
    logic signed [DELTA_W-1:0] delta_nxt;
    logic signed [SUM_W-1:0]   sum;
    logic [ACC_W-1:0]          acc_nxt;

    // Step and acceleration state for the frame latched in CALC.
    always_comb begin
        single     = dir_neg ^ dir_pos;
        hold_base  = hold;
        level_base = level;
        hold_nxt   = '0;
        level_nxt  = '0;
        delta_nxt  = '0;
        ana_ext    = {{(DELTA_W-8){ana[7]}}, ana};
        if (single && (dir_neg != last_neg)) begin
            hold_base  = '0;
            level_base = '0;
        end
        mag = DELTA_W'(1 << FRAC_W) << level_base;
        if (ana_sel) begin
            delta_nxt = ana_ext >>> ANA_SHIFT;
        end else if (single) begin
            delta_nxt = dir_neg ? -mag : mag;
            if (hold_base == HOLD_W'(ACCEL_FRAMES - 1)) begin
                hold_nxt  = '0;
                level_nxt = (level_base == LEVEL_W'(LEVEL_MAX)) ? level_base
                                                                 : level_base + LEVEL_W'(1);
            end else begin
                hold_nxt  = hold_base + HOLD_W'(1);
                level_nxt = level_base;
            end
        end
    end

    // Saturating add; the wide signed sum never wraps.
    always_comb begin
        sum = $signed({{(SUM_W-ACC_W){1'b0}}, acc})
            + $signed({{(SUM_W-DELTA_W){delta[DELTA_W-1]}}, delta});
        if (sum[SUM_W-1]) begin
            acc_nxt = '0;
        end else if (sum > SUM_TOP) begin
            acc_nxt = ACC_TOP;
        end else begin
            acc_nxt = sum[ACC_W-1:0];
        end
        changed_c = apply && (acc_nxt[ACC_W-1:FRAC_W] != acc[ACC_W-1:FRAC_W]);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            acc      <= ACC_RESET;
            hold     <= '0;
            level    <= '0;
            last_neg <= 1'b0;
            delta    <= '0;
        end else begin
            if (calc) begin
                hold  <= hold_nxt;
                level <= level_nxt;
                delta <= delta_nxt;
                if (single && !ana_sel) begin
                    last_neg <= dir_neg;
                end
            end
            if (apply) begin
                acc <= acc_nxt;
            end
        end
    end

    assign pos = acc[ACC_W-1:FRAC_W];

endmodule

// File: rtl/gun_position.sv
// Joystick (digital pad or analog stick) to Turkey Shoot lightgun coordinates.
// Define GUN_CROSSHAIR_EN to build the plus-shaped crosshair overlay.
module gun_position
    import gun_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             vblank,
    input  logic [3:0]       joy_dir,
    input  logic [7:0]       joy_ana_x,
    input  logic [7:0]       joy_ana_y,
    input  logic             ana_sel,
    input  logic [8:0]       hcnt,
    input  logic [8:0]       vcnt,
    output logic [POS_W-1:0] gun_h,
    output logic [POS_W-1:0] gun_v,
    output logic             moved,
    output logic             crosshair
);

    gun_state_t state;
    gun_state_t state_nxt;

    logic       vblank_d;
    logic       tick_c;
    logic       latch_c;
    logic       calc_c;
    logic       apply_c;
    logic [3:0] dir_q;
    logic [7:0] ana_x_q;
    logic [7:0] ana_y_q;
    logic       ana_sel_q;
    logic       changed_h_c;
    logic       changed_v_c;

    assign tick_c = vblank && !vblank_d;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch_c   = 1'b0;
        calc_c    = 1'b0;
        apply_c   = 1'b0;
        case (state)
            WAIT: begin
                if (tick_c) begin
                    latch_c   = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                calc_c    = 1'b1;
                state_nxt = APPLY;
            end
            APPLY: begin
                apply_c   = 1'b1;
                state_nxt = WAIT;
            end
            default: state_nxt = WAIT;
        endcase
    end

    // Frame inputs are frozen at the tick so CALC sees a consistent snapshot.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            vblank_d  <= 1'b0;
            dir_q     <= '0;
            ana_x_q   <= '0;
            ana_y_q   <= '0;
            ana_sel_q <= 1'b0;
            moved     <= 1'b0;
        end else begin
            vblank_d <= vblank;
            moved    <= changed_h_c | changed_v_c;
            if (latch_c) begin
                dir_q     <= joy_dir;
                ana_x_q   <= joy_ana_x;
                ana_y_q   <= joy_ana_y;
                ana_sel_q <= ana_sel;
            end
        end
    end

    gun_axis u_axis_h (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .calc      (calc_c),
        .apply     (apply_c),
        .ana_sel   (ana_sel_q),
        .dir_neg   (dir_q[2]),
        .dir_pos   (dir_q[3]),
        .ana       (ana_x_q),
        .pos       (gun_h),
        .changed_c (changed_h_c)
    );

    // Up moves the gun toward row 0.
    gun_axis u_axis_v (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .calc      (calc_c),
        .apply     (apply_c),
        .ana_sel   (ana_sel_q),
        .dir_neg   (dir_q[0]),
        .dir_pos   (dir_q[1]),
        .ana       (ana_y_q),
        .pos       (gun_v),
        .changed_c (changed_v_c)
    );

`ifdef GUN_CROSSHAIR_EN
    logic signed [7:0] dh;
    logic signed [7:0] dv;
    logic              cross_c;
    logic              unused_cnt_lsb;

    assign unused_cnt_lsb = ^{hcnt[1:0], vcnt[1:0]};

    // Plus shape: on the gun column within one row, or on the gun row within one column.
    always_comb begin
        dh      = $signed({1'b0, hcnt[8:2]}) - $signed({2'b00, gun_h});
        dv      = $signed({1'b0, vcnt[8:2]}) - $signed({2'b00, gun_v});
        cross_c = ((dh == 8'sd0) && (dv >= -8'sd1) && (dv <= 8'sd1))
               || ((dv == 8'sd0) && (dh >= -8'sd1) && (dh <= 8'sd1));
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            crosshair <= 1'b0;
        end else begin
            crosshair <= cross_c;
        end
    end
`else
    logic unused_cnt;

    assign unused_cnt = ^{hcnt, vcnt};
    assign crosshair  = 1'b0;
`endif

endmodule

// File: tb/tb_gun_position.sv
// Scoreboard bench for gun_position: each frame pushes its hand-computed
// position when a move is due; a monitor checks every moved pulse.
module tb_gun_position;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       vblank;
    logic [3:0] joy_dir;
    logic [7:0] joy_ana_x;
    logic [7:0] joy_ana_y;
    logic       ana_sel;
    logic [8:0] hcnt;
    logic [8:0] vcnt;
    logic [5:0] gun_h;
    logic [5:0] gun_v;
    logic       moved;
    logic       crosshair;

    int total = 0;
    int bad   = 0;
    int cur_h = 31;
    int cur_v = 31;
    logic [11:0] exp_q[$];

    gun_position dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .vblank    (vblank),
        .joy_dir   (joy_dir),
        .joy_ana_x (joy_ana_x),
        .joy_ana_y (joy_ana_y),
        .ana_sel   (ana_sel),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .gun_h     (gun_h),
        .gun_v     (gun_v),
        .moved     (moved),
        .crosshair (crosshair)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Monitor: every moved pulse must match the oldest outstanding expectation.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk_sys);
            if (moved) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_moved", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("moved_gun_h", int'(gun_h), int'(e[11:6]));
                    check("moved_gun_v", int'(gun_v), int'(e[5:0]));
                end
            end
        end
    end

    task automatic frame(input logic [3:0] dir, input logic [7:0] ax, input logic [7:0] ay,
                         input logic sel, input int eh, input int ev);
        joy_dir   = dir;
        joy_ana_x = ax;
        joy_ana_y = ay;
        ana_sel   = sel;
        if (eh != cur_h || ev != cur_v) begin
            exp_q.push_back({6'(eh), 6'(ev)});
        end
        cur_h = eh;
        cur_v = ev;
        @(negedge clk_sys);
        vblank = 1'b1;
        repeat (8) @(negedge clk_sys);
        vblank = 1'b0;
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_gun_h"}, int'(gun_h), cur_h);
        check({name, "_gun_v"}, int'(gun_v), cur_v);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        vblank    = 1'b0;
        joy_dir   = '0;
        joy_ana_x = '0;
        joy_ana_y = '0;
        ana_sel   = 1'b0;
        repeat (2) @(negedge clk_sys);
        check("rst_gun_h", int'(gun_h), 31);
        check("rst_gun_v", int'(gun_v), 31);
        check("rst_moved", int'(moved), 0);
        reset = 1'b0;
        cur_h = 31;
        cur_v = 31;
        @(negedge clk_sys);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int eh;
        int ev;
        int exp_cross;
        hcnt = '0;
        vcnt = '0;
        do_reset();
        check("rst_crosshair", int'(crosshair), 0);

        // Idle frame: nothing moves.
        frame(4'b0000, 8'h00, 8'h00, 1'b0, 31, 31);
        drain("idle");

        // Right held: 1 px x8, 2 px x8, then 4 px until clamped at 63.
        for (int f = 1; f <= 40; f++) begin
            if (f <= 8)        eh = 31 + f;
            else if (f <= 16)  eh = 39 + 2 * (f - 8);
            else if (f == 17)  eh = 59;
            else               eh = 63;
            frame(4'b1000, 8'h00, 8'h00, 1'b0, eh, 31);
        end
        drain("right_accel");

        // Reset during APPLY of a frame that would move right.
        do_reset();
        frame(4'b1000, 8'h00, 8'h00, 1'b0, 32, 31);
        drain("pre_midreset");
        @(negedge clk_sys);
        vblank = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b1;
        #1;
        check("midreset_gun_h", int'(gun_h), 31);
        check("midreset_moved", int'(moved), 0);
        vblank = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        cur_h = 31;
        cur_v = 31;
        repeat (6) @(negedge clk_sys);
        drain("midreset");

        // Opposing bits cancel and keep level at 0.
        for (int f = 0; f < 5; f++) frame(4'b1100, 8'h00, 8'h00, 1'b0, 31, 31);
        frame(4'b0100, 8'h00, 8'h00, 1'b0, 30, 31);
        drain("both_then_left");

        // Reversal after reaching level 1 restarts at 1 px.
        do_reset();
        for (int f = 1; f <= 8; f++) frame(4'b1000, 8'h00, 8'h00, 1'b0, 31 + f, 31);
        frame(4'b1000, 8'h00, 8'h00, 1'b0, 41, 31);
        frame(4'b0100, 8'h00, 8'h00, 1'b0, 40, 31);
        frame(4'b0100, 8'h00, 8'h00, 1'b0, 39, 31);
        frame(4'b0001, 8'h00, 8'h00, 1'b0, 39, 30);
        frame(4'b0010, 8'h00, 8'h00, 1'b0, 39, 31);
        drain("reversal");

        // Analog full negative Y down to 0, then no wrap; joy_dir ignored.
        do_reset();
        for (int f = 1; f <= 31; f++) frame(4'b1000, 8'h00, 8'h80, 1'b1, 31, 31 - f);
        frame(4'b1000, 8'h00, 8'h80, 1'b1, 31, 0);
        drain("analog_floor");

        // Analog +127 gives 15/16 px: first frame stays on 31.
        do_reset();
        frame(4'b0000, 8'h7f, 8'h00, 1'b1, 31, 31);
        frame(4'b0000, 8'h7f, 8'h00, 1'b1, 32, 31);
        drain("analog_pos");

        // Steer to (10,20) for the crosshair probe.
        do_reset();
        for (int f = 1; f <= 21; f++) begin
            ev = (f <= 11) ? 31 - f : 20;
            frame(4'b0000, 8'h80, (f <= 11) ? 8'h80 : 8'h00, 1'b1, 31 - f, ev);
        end
        drain("steer");
`ifdef GUN_CROSSHAIR_EN
        exp_cross = 1;
`else
        exp_cross = 0;
`endif
        hcnt = 9'd40;
        vcnt = 9'd84;
        repeat (2) @(negedge clk_sys);
        check("crosshair_on", int'(crosshair), exp_cross);
        hcnt = 9'd48;
        repeat (2) @(negedge clk_sys);
        check("crosshair_off", int'(crosshair), 0);

        drain("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
